// File: rtl/timer_hms_param.sv
// rtl/timer_hms_param.sv - parametrised hours:minutes:seconds timer with prescaler, up/down, preset and alarm
//
// Ports:
//   clk_i, reset_ni              clock (rising edge), asynchronous active-low reset
//   en_i, down_i                 run enable, count direction (1 = down)
//   load_i, alarm_we_i           preset time / write alarm from load_* buses
//   load_sec_i/min_i/hour_i      preset or alarm value (clamped into range)
//   sec_o, min_o, hour_o         current time
//   tick_o, wrap_o, alarm_o      one-cycle event pulses, aligned with the new time
//   expired_o                    level, down-count held at 00:00:00
module timer_hms_param #(
    parameter int TICK_DIV = 100,
    parameter int HOUR_MOD = 24,
    parameter int W        = 6
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         en_i,
    input  logic         down_i,
    input  logic         load_i,
    input  logic         alarm_we_i,
    input  logic [W-1:0] load_sec_i,
    input  logic [W-1:0] load_min_i,
    input  logic [W-1:0] load_hour_i,
    output logic [W-1:0] sec_o,
    output logic [W-1:0] min_o,
    output logic [W-1:0] hour_o,
    output logic         tick_o,
    output logic         wrap_o,
    output logic         alarm_o,
    output logic         expired_o
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [W-1:0]  MAX_MS     = W'(59);
    localparam logic [W-1:0]  MAX_H      = W'(HOUR_MOD - 1);

    logic [PW-1:0] presc;
    logic [W-1:0]  alarm_sec, alarm_min, alarm_hour;
    logic          alarm_armed;

    logic [W-1:0]  cl_sec, cl_min, cl_hour;
    logic [W-1:0]  nxt_sec, nxt_min, nxt_hour;
    logic          tick, at_zero, at_top, advance, nxt_zero, cl_zero, nxt_is_alarm;

    function automatic logic [W-1:0] clamp(input logic [W-1:0] v, input logic [W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    assign cl_sec  = clamp(load_sec_i, MAX_MS);
    assign cl_min  = clamp(load_min_i, MAX_MS);
    assign cl_hour = clamp(load_hour_i, MAX_H);
    assign cl_zero = (cl_sec == '0) && (cl_min == '0) && (cl_hour == '0);

    // Load owns the cycle: the prescaler does not run and no tick is produced.
    assign tick    = en_i && !load_i && (presc == PRESC_LAST);
    assign at_zero = (sec_o == '0) && (min_o == '0) && (hour_o == '0);
    assign at_top  = (sec_o == MAX_MS) && (min_o == MAX_MS) && (hour_o == MAX_H);
    // A down tick at 00:00:00 is swallowed: time holds and no tick_o.
    assign advance = tick && !(down_i && at_zero);

    always_comb begin
        nxt_sec  = sec_o;
        nxt_min  = min_o;
        nxt_hour = hour_o;
        if (!down_i) begin
            if (sec_o == MAX_MS) begin
                nxt_sec = '0;
                if (min_o == MAX_MS) begin
                    nxt_min  = '0;
                    nxt_hour = (hour_o == MAX_H) ? '0 : hour_o + 1'b1;
                end else begin
                    nxt_min = min_o + 1'b1;
                end
            end else begin
                nxt_sec = sec_o + 1'b1;
            end
        end else if (!at_zero) begin
            if (sec_o == '0) begin
                nxt_sec = MAX_MS;
                if (min_o == '0) begin
                    nxt_min  = MAX_MS;
                    nxt_hour = hour_o - 1'b1;
                end else begin
                    nxt_min = min_o - 1'b1;
                end
            end else begin
                nxt_sec = sec_o - 1'b1;
            end
        end
    end

    assign nxt_zero     = (nxt_sec == '0) && (nxt_min == '0) && (nxt_hour == '0);
    assign nxt_is_alarm = (nxt_sec == alarm_sec) && (nxt_min == alarm_min) && (nxt_hour == alarm_hour);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            presc       <= '0;
            sec_o       <= '0;
            min_o       <= '0;
            hour_o      <= '0;
            alarm_sec   <= '0;
            alarm_min   <= '0;
            alarm_hour  <= '0;
            alarm_armed <= 1'b0;
            tick_o      <= 1'b0;
            wrap_o      <= 1'b0;
            alarm_o     <= 1'b0;
            expired_o   <= 1'b0;
        end else begin
            tick_o  <= 1'b0;
            wrap_o  <= 1'b0;
            alarm_o <= 1'b0;

            if (alarm_we_i) begin
                alarm_sec   <= cl_sec;
                alarm_min   <= cl_min;
                alarm_hour  <= cl_hour;
                alarm_armed <= 1'b1;
            end

            if (load_i) begin
                presc  <= '0;
                sec_o  <= cl_sec;
                min_o  <= cl_min;
                hour_o <= cl_hour;
                if (!cl_zero) begin
                    expired_o <= 1'b0;
                end
            end else if (en_i) begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
                if (advance) begin
                    sec_o   <= nxt_sec;
                    min_o   <= nxt_min;
                    hour_o  <= nxt_hour;
                    tick_o  <= 1'b1;
                    wrap_o  <= !down_i && at_top;
                    alarm_o <= alarm_armed && nxt_is_alarm;
                end
                // Covers both reaching zero and a swallowed tick at zero.
                if (tick && down_i && nxt_zero) begin
                    expired_o <= 1'b1;
                end
            end

            // Switching to up-count always releases the expired state.
            if (!down_i) begin
                expired_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_timer_hms_param.sv
// tb/tb_timer_hms_param.sv - scoreboard bench for timer_hms_param (TICK_DIV=4 and TICK_DIV=1 instances)
module tb_timer_hms_param;

    localparam int W = 7;

    logic         clk;
    logic         rst_n;
    logic         en, dn, ld, aw;
    logic [W-1:0] ls, lm, lh;

    logic [W-1:0] sec0, min0, hour0, sec1, min1, hour1;
    logic         tick0, wrap0, alarm0, exp0, tick1, wrap1, alarm1, exp1;

    typedef struct {
        string        tag;
        int           dut;
        logic [W-1:0] h, m, s;
        logic         t, w, a, x;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    timer_hms_param #(.TICK_DIV(4), .HOUR_MOD(24), .W(W)) u_div4 (
        .clk_i(clk), .reset_ni(rst_n), .en_i(en), .down_i(dn), .load_i(ld), .alarm_we_i(aw),
        .load_sec_i(ls), .load_min_i(lm), .load_hour_i(lh),
        .sec_o(sec0), .min_o(min0), .hour_o(hour0),
        .tick_o(tick0), .wrap_o(wrap0), .alarm_o(alarm0), .expired_o(exp0)
    );

    timer_hms_param #(.TICK_DIV(1), .HOUR_MOD(24), .W(W)) u_div1 (
        .clk_i(clk), .reset_ni(rst_n), .en_i(en), .down_i(dn), .load_i(ld), .alarm_we_i(aw),
        .load_sec_i(ls), .load_min_i(lm), .load_hour_i(lh),
        .sec_o(sec1), .min_o(min1), .hour_o(hour1),
        .tick_o(tick1), .wrap_o(wrap1), .alarm_o(alarm1), .expired_o(exp1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_t(input string tag, input int dut, input int h, input int m, input int s,
                            input logic t, input logic w, input logic a, input logic x);
        exp_t e;
        e.tag = tag; e.dut = dut;
        e.h = W'(h); e.m = W'(m); e.s = W'(s);
        e.t = t; e.w = w; e.a = a; e.x = x;
        sb.push_back(e);
    endtask

    task automatic flush();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                check({e.tag, ".hour"}, 32'(hour0), 32'(e.h));
                check({e.tag, ".min"},  32'(min0),  32'(e.m));
                check({e.tag, ".sec"},  32'(sec0),  32'(e.s));
                check({e.tag, ".tick"}, 32'(tick0), 32'(e.t));
                check({e.tag, ".wrap"}, 32'(wrap0), 32'(e.w));
                check({e.tag, ".alarm"}, 32'(alarm0), 32'(e.a));
                check({e.tag, ".expired"}, 32'(exp0), 32'(e.x));
            end else begin
                check({e.tag, ".hour"}, 32'(hour1), 32'(e.h));
                check({e.tag, ".min"},  32'(min1),  32'(e.m));
                check({e.tag, ".sec"},  32'(sec1),  32'(e.s));
                check({e.tag, ".tick"}, 32'(tick1), 32'(e.t));
                check({e.tag, ".wrap"}, 32'(wrap1), 32'(e.w));
                check({e.tag, ".alarm"}, 32'(alarm1), 32'(e.a));
                check({e.tag, ".expired"}, 32'(exp1), 32'(e.x));
            end
        end
    endtask

    // Expectations pushed before an edge are compared just after it.
    always @(posedge clk) begin
        #1;
        flush();
    end

    task automatic drive(input logic e_, input logic d_, input logic l_, input logic a_,
                         input int h, input int m, input int s);
        en = e_; dn = d_; ld = l_; aw = a_;
        lh = W'(h); lm = W'(m); ls = W'(s);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #3;
        expect_t("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        expect_t("reset", 1, 0, 0, 0, 0, 0, 0, 0);
        flush();
        @(negedge clk);
        rst_n = 1'b1;

        // Prescaler of 4: a tick every 4th enabled cycle.
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            expect_t($sformatf("div4_c%0d", k), 0, 0, 0, k / 4, (k % 4) == 0, 0, 0, 0);
            step();
        end

        // Day wrap on the up count.
        drive(1, 0, 1, 0, 23, 59, 58);
        expect_t("wrap_load", 1, 23, 59, 58, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_t("wrap_c1", 1, 23, 59, 59, 1, 0, 0, 0); step();
        expect_t("wrap_c2", 1, 0, 0, 0, 1, 1, 0, 0);    step();
        expect_t("wrap_c3", 1, 0, 0, 1, 1, 0, 0, 0);    step();

        // Down count with borrow, then expiry at zero.
        drive(1, 1, 1, 0, 1, 0, 1);
        expect_t("dn_load", 1, 1, 0, 1, 0, 0, 0, 0); step();
        drive(1, 1, 0, 0, 0, 0, 0);
        expect_t("dn_c1", 1, 1, 0, 0, 1, 0, 0, 0);    step();
        expect_t("dn_c2", 1, 0, 59, 59, 1, 0, 0, 0);  step();
        drive(1, 1, 1, 0, 0, 0, 1);
        expect_t("dn_load1", 1, 0, 0, 1, 0, 0, 0, 0); step();
        drive(1, 1, 0, 0, 0, 0, 0);
        expect_t("dn_zero", 1, 0, 0, 0, 1, 0, 0, 1);  step();
        expect_t("dn_hold1", 1, 0, 0, 0, 0, 0, 0, 1); step();
        expect_t("dn_hold2", 1, 0, 0, 0, 0, 0, 0, 1); step();
        drive(1, 1, 1, 0, 0, 0, 5);
        expect_t("dn_reload", 1, 0, 0, 5, 0, 0, 0, 0); step();

        // Alarm at 0:0:3 fires once when counted into, not when loaded.
        drive(0, 0, 0, 1, 0, 0, 3);
        expect_t("al_write", 1, 0, 0, 5, 0, 0, 0, 0); step();
        drive(1, 0, 1, 0, 0, 0, 0);
        expect_t("al_load0", 1, 0, 0, 0, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int s = 1; s <= 4; s++) begin
            expect_t($sformatf("al_s%0d", s), 1, 0, 0, s, 1, 0, s == 3, 0);
            step();
        end
        drive(1, 0, 1, 0, 0, 0, 3);
        expect_t("al_load3", 1, 0, 0, 3, 0, 0, 0, 0); step();

        // Clamping and freeze.
        drive(1, 0, 1, 0, 70, 70, 70);
        expect_t("clamp", 1, 23, 59, 59, 0, 0, 0, 0);
        expect_t("clamp", 0, 23, 59, 59, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            expect_t($sformatf("freeze%0d", k), 1, 23, 59, 59, 0, 0, 0, 0);
            expect_t($sformatf("freeze%0d", k), 0, 23, 59, 59, 0, 0, 0, 0);
            step();
        end

        // Asynchronous reset mid-count disarms the alarm.
        drive(0, 0, 0, 1, 0, 0, 2);
        expect_t("rs_alarm", 1, 23, 59, 59, 0, 0, 0, 0); step();
        drive(1, 0, 1, 0, 12, 34, 56);
        expect_t("rs_load", 1, 12, 34, 56, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_t("rs_async", 1, 0, 0, 0, 0, 0, 0, 0);
        expect_t("rs_async", 0, 0, 0, 0, 0, 0, 0, 0);
        flush();
        @(negedge clk);
        rst_n = 1'b1;
        expect_t("rs_c1", 1, 0, 0, 1, 1, 0, 0, 0); step();
        expect_t("rs_c2", 1, 0, 0, 2, 1, 0, 0, 0); step();
        expect_t("rs_c3", 1, 0, 0, 3, 1, 0, 0, 0); step();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_hms_param.md
Name: timer_hms_param

Overview:
- Parametrised successor to the team's sec/min/hour timer.
- Counts hours:minutes:seconds from a programmable clock prescaler.
- Adds run enable, up/down mode, synchronous preset load, alarm compare and status pulses.
- Sits under the display/control logic: it feeds the digit decoders and raises event pulses to the control FSM.

Parameters:
- TICK_DIV, 100, clk_i cycles per second tick (>=1); TICK_DIV=1 means every enabled cycle is a tick.
- HOUR_MOD, 24, hour modulus (hours run 0..HOUR_MOD-1; 12 or 24 in practice, legal 2..64).
- W, 6, width of sec/min/hour fields (>=6).

Ports:
- clk_i  in  1  system clock, rising edge
- reset_ni  in  1  asynchronous active-low reset
- en_i  in  1  run enable; 0 freezes prescaler and time
- down_i  in  1  0 = count up, 1 = count down
- load_i  in  1  synchronous preset of time from load_* buses
- alarm_we_i  in  1  synchronous write of alarm registers from load_* buses
- load_sec_i  in  W  preset/alarm seconds
- load_min_i  in  W  preset/alarm minutes
- load_hour_i  in  W  preset/alarm hours
- sec_o  out  W  current seconds 0..59
- min_o  out  W  current minutes 0..59
- hour_o  out  W  current hours 0..HOUR_MOD-1
- tick_o  out  1  one-cycle pulse in the cycle the time value advances
- wrap_o  out  1  one-cycle pulse on day wrap (up: 23:59:59->00:00:00; down: 00:00:00 never wraps, see expired_o)
- alarm_o  out  1  one-cycle pulse when the newly advanced time equals the alarm registers
- expired_o  out  1  level; 1 while down-counting is held at 00:00:00

Behaviour:
- Reset (reset_ni=0, asynchronous): time=0:0:0, prescaler=0, alarm regs=0, alarm_armed=0; all outputs 0.
- Prescaler: counts 0..TICK_DIV-1 while en_i=1 and load_i=0. A tick occurs in the cycle it equals TICK_DIV-1; it then returns to 0.
- The time registers update on the tick edge, so new values are visible the cycle after the terminal prescaler count. tick_o is registered and asserts in the same cycle as the new time.
- Up count: sec 59->0 carries to min; min 59->0 carries to hour; hour HOUR_MOD-1->0 with wrap_o=1.
- Down count:
  - sec 0->59 borrows from min; min 0->59 borrows from hour.
  - At 00:00:00 a tick does not change the time, tick_o stays 0, and expired_o=1.
  - expired_o clears when time becomes non-zero (load) or when down_i=0.
- en_i=0: prescaler and time hold; tick_o/wrap_o/alarm_o are 0.
- load_i=1 (priority over counting):
  - Next cycle, time = load values and prescaler = 0; no tick is generated that cycle.
  - Out-of-range values clamp: sec/min >59 -> 59, hour >HOUR_MOD-1 -> HOUR_MOD-1.
- alarm_we_i=1:
  - Alarm regs take the clamped load values and alarm_armed=1.
  - load_i and alarm_we_i together load both.
- alarm_o: pulses in the tick_o cycle when alarm_armed=1 and the new time equals the alarm regs. A load to a matching value does not trigger it. The alarm stays armed and retriggers every occurrence.
- down_i change mid-count: takes effect at the next tick; the prescaler phase is kept.
- Status pulses are never wider than one cycle, even with TICK_DIV=1 producing consecutive ticks (each tick gives its own pulse).
- Reset mid-operation: immediate return to reset state irrespective of the clock; alarm is disarmed.

Test Plan:
- TICK_DIV=4, reset then en_i=1 for 16 cycles -> tick_o pulses every 4th cycle; sec_o steps 1,2,3,4; min_o=hour_o=0.
- TICK_DIV=1, load 23:59:58, up, 3 cycles -> 23:59:59, then 00:00:00 with wrap_o=1, then 00:00:01 with wrap_o=0.
- TICK_DIV=1, load 1:00:01, down_i=1 -> 1:00:00, 0:59:59; then load 0:00:01 -> 0:00:00 with expired_o=1; time holds and tick_o=0 on further cycles; load 0:00:05 -> expired_o=0.
- TICK_DIV=1, alarm_we_i with 0:0:3, load 0:0:0, count up -> alarm_o single pulse in the cycle sec_o becomes 3; loading 0:0:3 directly -> no alarm_o.
- Load 70:70:70 with HOUR_MOD=24 -> 23:59:59; en_i=0 for 10 cycles -> values frozen and no pulses.
- Assert reset_ni low between clock edges mid-count at 12:34:56 -> outputs go to 0 immediately; after release, alarm_o never fires until the alarm is rewritten.
